ramp_tick_gen: RTL and testbench

Programmable prescaler that produces the single-cycle `ena` shift strobe for the bouncing one-hot shift register. Each `TC` pulse from that register marks one completed sweep, and the block uses it to change the strobe interval: the interval shrinks sweep by sweep to a floor, then grows back to the start value, and repeats. The block sits directly upstream of the shift register and takes its `TC` output as feedback.

---
 rtl/shiftreg_pkg.sv | 17 +
 rtl/ramp_tick_gen_rise_detect.sv | 25 ++
 rtl/ramp_tick_gen.sv | 137 +++++++++++++
 tb/tb_ramp_tick_gen.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the bouncing shift register and its ramp prescaler:
// FSM state encodings and the default interval width.
package shiftreg_pkg;

  localparam int DIV_WIDTH_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCEL = 2'd1;
  localparam logic [1:0] ST_DECEL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCEL = ST_ACCEL,
    S_DECEL = ST_DECEL
  } state_t;

endpackage

// File: rtl/ramp_tick_gen_rise_detect.sv
// Registered 1-bit rising-edge detector; o_rise is a one-cycle pulse the
// cycle after d is first seen high.
module rise_detect (
  input  logic clk,
  input  logic rsta,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_d;
      r_rise <= i_d & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: issues a one-cycle ena strobe every cur_div cycles and walks
// cur_div down to a floor and back up, one step per sweep-complete edge.
module ramp_tick_gen
  import shiftreg_pkg::*;
#(
  parameter int DIV_WIDTH = shiftreg_pkg::DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rsta,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 tc_in,
  input  logic [DIV_WIDTH-1:0] div_init,
  input  logic [DIV_WIDTH-1:0] div_min,
  input  logic [DIV_WIDTH-1:0] div_step,
  output logic                 ena,
  output logic                 busy,
  output logic                 decel,
  output logic [DIV_WIDTH-1:0] cur_div,
  output logic [CNT_WIDTH-1:0] ramp_count
);

  state_t               r_state,      w_state_next;
  logic [DIV_WIDTH-1:0] r_cnt,        w_cnt_next;
  logic [DIV_WIDTH-1:0] r_cur_div,    w_cur_div_next;
  logic [DIV_WIDTH-1:0] r_min_eff,    w_min_eff_next;
  logic [DIV_WIDTH-1:0] r_init_eff,   w_init_eff_next;
  logic [DIV_WIDTH-1:0] r_step,       w_step_next;
  logic [CNT_WIDTH-1:0] r_ramp_count, w_ramp_count_next;
  logic                 r_ena,        w_ena_next;

  logic                 w_tc_rise;
  logic [DIV_WIDTH-1:0] w_init_s;
  logic [DIV_WIDTH-1:0] w_min_s;
  logic [DIV_WIDTH:0]   w_diff;
  logic [DIV_WIDTH:0]   w_sum;

  rise_detect u_tc_rise (
    .clk    (clk),
    .rsta   (rsta),
    .i_d    (tc_in),
    .o_rise (w_tc_rise)
  );

  // A zero interval would never fire, so it is read as the fastest rate.
  assign w_init_s = (div_init == '0) ? DIV_WIDTH'(1) : div_init;
  assign w_min_s  = (div_min  == '0) ? DIV_WIDTH'(1) : div_min;

  assign w_diff = {1'b0, r_cur_div} - {1'b0, r_step};
  assign w_sum  = {1'b0, r_cur_div} + {1'b0, r_step};

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cur_div    <= '0;
      r_min_eff    <= '0;
      r_init_eff   <= '0;
      r_step       <= '0;
      r_ramp_count <= '0;
      r_ena        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_cur_div    <= w_cur_div_next;
      r_min_eff    <= w_min_eff_next;
      r_init_eff   <= w_init_eff_next;
      r_step       <= w_step_next;
      r_ramp_count <= w_ramp_count_next;
      r_ena        <= w_ena_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_cur_div_next    = r_cur_div;
    w_min_eff_next    = r_min_eff;
    w_init_eff_next   = r_init_eff;
    w_step_next       = r_step;
    w_ramp_count_next = r_ramp_count;
    w_ena_next        = 1'b0;

    if (stop) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        w_min_eff_next  = (w_min_s <= w_init_s) ? w_min_s : w_init_s;
        w_init_eff_next = (w_min_s <= w_init_s) ? w_init_s : w_min_s;
        w_step_next     = div_step;
        w_cur_div_next  = w_init_eff_next;
        w_cnt_next      = w_init_eff_next - DIV_WIDTH'(1);
        w_state_next    = S_ACCEL;
      end
    end else if (r_state == S_ACCEL || r_state == S_DECEL) begin
      // Reload from the interval currently in force; a pending update to
      // cur_div only takes effect at the following reload.
      if (r_cnt == '0) begin
        w_ena_next = 1'b1;
        w_cnt_next = r_cur_div - DIV_WIDTH'(1);
      end else begin
        w_cnt_next = r_cnt - DIV_WIDTH'(1);
      end

      if (w_tc_rise && (r_step != '0)) begin
        if (r_state == S_ACCEL) begin
          if (w_diff[DIV_WIDTH] || (w_diff <= {1'b0, r_min_eff})) begin
            w_cur_div_next = r_min_eff;
            w_state_next   = S_DECEL;
          end else begin
            w_cur_div_next = w_diff[DIV_WIDTH-1:0];
          end
        end else begin
          if (w_sum >= {1'b0, r_init_eff}) begin
            w_cur_div_next    = r_init_eff;
            w_state_next      = S_ACCEL;
            w_ramp_count_next = r_ramp_count + CNT_WIDTH'(1);
          end else begin
            w_cur_div_next = w_sum[DIV_WIDTH-1:0];
          end
        end
      end
    end else begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
  end

  assign ena        = r_ena;
  assign busy       = (r_state != S_IDLE);
  assign decel      = (r_state == S_DECEL);
  assign cur_div    = r_cur_div;
  assign ramp_count = r_ramp_count;

endmodule

// File: tb/tb_ramp_tick_gen.sv
// Directed bench for ramp_tick_gen: strobe timing, ramp sequencing, stop and reset.
module tb_ramp_tick_gen;

  logic        clk;
  logic        rsta;
  logic        start;
  logic        stop;
  logic        tc_in;
  logic [15:0] div_init;
  logic [15:0] div_min;
  logic [15:0] div_step;
  logic        ena;
  logic        busy;
  logic        decel;
  logic [15:0] cur_div;
  logic [7:0]  ramp_count;

  int checks   = 0;
  int failures = 0;

  ramp_tick_gen #(.DIV_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rsta       (rsta),
    .start      (start),
    .stop       (stop),
    .tc_in      (tc_in),
    .div_init   (div_init),
    .div_min    (div_min),
    .div_step   (div_step),
    .ena        (ena),
    .busy       (busy),
    .decel      (decel),
    .cur_div    (cur_div),
    .ramp_count (ramp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rsta = 1'b1; start = 1'b0; stop = 1'b0; tc_in = 1'b0;
    tick(); tick();
    rsta = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [15:0] i_init, input logic [15:0] i_min,
                          input logic [15:0] i_step);
    div_init = i_init; div_min = i_min; div_step = i_step;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_tc();
    tc_in = 1'b1;
    tick();
    tc_in = 1'b0;
    tick();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rsta = 1'b1; start = 1'b0; stop = 1'b0; tc_in = 1'b0;
    div_init = '0; div_min = '0; div_step = '0;
    #1;
    checks++; if (ena !== 1'b0) begin failures++; $display("FAIL reset_ena got=%0b exp=0", ena); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (decel !== 1'b0) begin failures++; $display("FAIL reset_decel got=%0b exp=0", decel); end
    checks++; if (cur_div !== 16'd0) begin failures++; $display("FAIL reset_cur_div got=%0d exp=0", cur_div); end
    checks++; if (ramp_count !== 8'd0) begin failures++; $display("FAIL reset_ramp_count got=%0d exp=0", ramp_count); end
    tick(); tick();
    rsta = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  // init=4: strobes at 4, 8, 12 after start; a start while busy is ignored.
  task automatic test_basic();
    logic exp_ena;
    apply_reset();
    do_start(16'd4, 16'd2, 16'd1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    checks++; if (cur_div !== 16'd4) begin failures++; $display("FAIL basic_cur_div got=%0d exp=4", cur_div); end
    for (int n = 1; n <= 12; n++) begin
      if (n == 2) begin start = 1'b1; div_init = 16'd9; end
      if (n == 3) start = 1'b0;
      tick();
      exp_ena = ((n % 4) == 0);
      checks++;
      if (ena !== exp_ena) begin
        failures++; $display("FAIL basic_ena n=%0d got=%0b exp=%0b", n, ena, exp_ena);
      end
    end
    checks++; if (cur_div !== 16'd4) begin failures++; $display("FAIL basic_cur_div_end got=%0d exp=4", cur_div); end
    checks++; if (decel !== 1'b0) begin failures++; $display("FAIL basic_decel got=%0b exp=0", decel); end
    do_stop();
    $display("test_basic done");
  endtask

  // One tc pulse: interval in flight still ends at 4, then 3-cycle spacing.
  task automatic test_one_tc();
    logic exp_ena;
    apply_reset();
    do_start(16'd4, 16'd2, 16'd1);
    for (int n = 1; n <= 13; n++) begin
      tick();
      if (n == 1) tc_in = 1'b1;
      if (n == 2) begin
        tc_in = 1'b0;
        checks++; if (cur_div !== 16'd4) begin failures++; $display("FAIL one_tc_pre got=%0d exp=4", cur_div); end
      end
      if (n == 3) begin
        checks++; if (cur_div !== 16'd3) begin failures++; $display("FAIL one_tc_post got=%0d exp=3", cur_div); end
      end
      exp_ena = (n == 4) || (n == 7) || (n == 10) || (n == 13);
      checks++;
      if (ena !== exp_ena) begin
        failures++; $display("FAIL one_tc_ena n=%0d got=%0b exp=%0b", n, ena, exp_ena);
      end
    end
    do_stop();
    $display("test_one_tc done");
  endtask

  task automatic test_sweep();
    logic [15:0] exp_cur [5]  = '{16'd3, 16'd2, 16'd3, 16'd4, 16'd3};
    logic        exp_dec [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  exp_ramp [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    apply_reset();
    do_start(16'd4, 16'd2, 16'd1);
    for (int p = 0; p < 5; p++) begin
      pulse_tc();
      checks++;
      if (cur_div !== exp_cur[p] || decel !== exp_dec[p] || ramp_count !== exp_ramp[p]) begin
        failures++;
        $display("FAIL sweep p=%0d got cur=%0d decel=%0b ramp=%0d exp cur=%0d decel=%0b ramp=%0d",
                 p, cur_div, decel, ramp_count, exp_cur[p], exp_dec[p], exp_ramp[p]);
      end
      tick();
    end
    do_stop();
    checks++;
    if (busy !== 1'b0 || cur_div !== 16'd3 || ramp_count !== 8'd1) begin
      failures++;
      $display("FAIL sweep_stop_hold got busy=%0b cur=%0d ramp=%0d exp busy=0 cur=3 ramp=1",
               busy, cur_div, ramp_count);
    end
    $display("test_sweep done");
  endtask

  // init < min: limits are swapped; large step saturates both ways.
  task automatic test_swap();
    apply_reset();
    do_start(16'd3, 16'd7, 16'd100);
    checks++; if (cur_div !== 16'd7) begin failures++; $display("FAIL swap_init got=%0d exp=7", cur_div); end
    for (int n = 1; n <= 7; n++) begin
      tick();
      checks++;
      if (ena !== (n == 7)) begin
        failures++; $display("FAIL swap_ena n=%0d got=%0b exp=%0b", n, ena, (n == 7));
      end
    end
    pulse_tc();
    checks++;
    if (cur_div !== 16'd3 || decel !== 1'b1) begin
      failures++; $display("FAIL swap_down got cur=%0d decel=%0b exp cur=3 decel=1", cur_div, decel);
    end
    tick();
    pulse_tc();
    checks++;
    if (cur_div !== 16'd7 || decel !== 1'b0 || ramp_count !== 8'd1) begin
      failures++;
      $display("FAIL swap_up got cur=%0d decel=%0b ramp=%0d exp cur=7 decel=0 ramp=1",
               cur_div, decel, ramp_count);
    end
    do_stop();
    $display("test_swap done");
  endtask

  task automatic test_held_tc();
    apply_reset();
    do_start(16'd4, 16'd2, 16'd1);
    tc_in = 1'b1;
    for (int n = 0; n < 20; n++) tick();
    tc_in = 1'b0;
    tick();
    checks++;
    if (cur_div !== 16'd3 || decel !== 1'b0) begin
      failures++; $display("FAIL held_tc got cur=%0d decel=%0b exp cur=3 decel=0", cur_div, decel);
    end
    do_stop();
    $display("test_held_tc done");
  endtask

  task automatic test_step_zero();
    apply_reset();
    do_start(16'd5, 16'd2, 16'd0);
    pulse_tc(); tick(); pulse_tc();
    checks++;
    if (cur_div !== 16'd5 || decel !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL step_zero got cur=%0d decel=%0b busy=%0b exp cur=5 decel=0 busy=1",
               cur_div, decel, busy);
    end
    do_stop();
    $display("test_step_zero done");
  endtask

  // Zero init/min read as 1: ena stays high every cycle while busy.
  task automatic test_div_one();
    apply_reset();
    do_start(16'd0, 16'd0, 16'd5);
    checks++; if (cur_div !== 16'd1) begin failures++; $display("FAIL div1_cur got=%0d exp=1", cur_div); end
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (ena !== 1'b1) begin failures++; $display("FAIL div1_ena n=%0d got=%0b exp=1", n, ena); end
    end
    do_stop();
    checks++; if (ena !== 1'b0) begin failures++; $display("FAIL div1_stop_ena got=%0b exp=0", ena); end
    $display("test_div_one done");
  endtask

  task automatic test_start_stop();
    int ena_seen = 0;
    apply_reset();
    div_init = 16'd2; div_min = 16'd1; div_step = 16'd1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (ena === 1'b1 || busy === 1'b1) ena_seen++;
      tick();
    end
    checks++;
    if (ena_seen != 0) begin failures++; $display("FAIL start_stop active_cycles got=%0d exp=0", ena_seen); end
    $display("test_start_stop done");
  endtask

  task automatic test_stop_mid();
    int ena_seen = 0;
    apply_reset();
    do_start(16'd4, 16'd2, 16'd1);
    pulse_tc();
    do_stop();
    checks++;
    if (busy !== 1'b0 || ena !== 1'b0 || cur_div !== 16'd3 || ramp_count !== 8'd0) begin
      failures++;
      $display("FAIL stop_mid got busy=%0b ena=%0b cur=%0d ramp=%0d exp busy=0 ena=0 cur=3 ramp=0",
               busy, ena, cur_div, ramp_count);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      if (ena === 1'b1) ena_seen++;
    end
    checks++;
    if (ena_seen != 0) begin failures++; $display("FAIL stop_mid_ena count got=%0d exp=0", ena_seen); end
    $display("test_stop_mid done");
  endtask

  task automatic test_rst_mid();
    int ena_seen = 0;
    apply_reset();
    do_start(16'd2, 16'd1, 16'd1);
    pulse_tc(); tick(); pulse_tc();
    checks++;
    if (ramp_count !== 8'd1 || cur_div !== 16'd2) begin
      failures++; $display("FAIL rst_mid_pre got cur=%0d ramp=%0d exp cur=2 ramp=1", cur_div, ramp_count);
    end
    tick();
    #2;
    rsta = 1'b1;
    #1;
    checks++;
    if (ena !== 1'b0 || busy !== 1'b0 || decel !== 1'b0 || cur_div !== 16'd0 || ramp_count !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid got ena=%0b busy=%0b decel=%0b cur=%0d ramp=%0d exp all 0",
               ena, busy, decel, cur_div, ramp_count);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      if (ena === 1'b1) ena_seen++;
    end
    rsta = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (ena === 1'b1 || busy === 1'b1) ena_seen++;
    end
    checks++;
    if (ena_seen != 0) begin failures++; $display("FAIL rst_mid_after active_cycles got=%0d exp=0", ena_seen); end
    $display("test_rst_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_tc();
    test_sweep();
    test_swap();
    test_held_tc();
    test_step_zero();
    test_div_one();
    test_start_stop();
    test_stop_mid();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
